// File: rtl/adc_event_sequencer.sv
// ADC event sequencer: captures triggered events into an external sample buffer, then streams them out channel by channel.
// Optional header word per event is enabled with the ADC_EVT_HEADER_EN macro.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for an enabled trigger with a non-zero sample count
// S_CAPTURE | writing n_lat samples to the buffer, addresses 0..n_lat-1
// S_READOUT | issuing sample-major buffer reads into the 2-entry skid buffer
// S_FLUSH   | all reads issued; draining the skid buffer up to the last word
module adc_event_sequencer #(
   parameter int NCH     = 64,
   parameter int NSAMP_W = 8,
   parameter int CNT_W   = 16,
   localparam int CH_W   = $clog2(NCH),
   localparam int RD_W   = NSAMP_W + CH_W
) (
   input  logic               adc_clk,
   input  logic               rst_n,
   input  logic               trigger_i,
   input  logic               cfg_enable_i,
   input  logic [NSAMP_W-1:0] cfg_nsamples_i,
   output logic               buf_wr_en_o,
   output logic [NSAMP_W-1:0] buf_wr_addr_o,
   output logic               buf_rd_en_o,
   output logic [RD_W-1:0]    buf_rd_addr_o,
   input  logic [11:0]        buf_rd_data_i,
   output logic [15:0]        out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               out_last_o,
   output logic               busy_o,
   output logic [CNT_W-1:0]   evt_cnt_o,
   output logic [CNT_W-1:0]   trig_lost_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_READOUT,
      S_FLUSH
   } state_t;

   state_t state_q, state_d;

   logic [NSAMP_W-1:0] n_lat_q;
   logic [NSAMP_W-1:0] n_last;
   logic               wr_en_q;
   logic [NSAMP_W-1:0] wr_addr_q;
   logic [RD_W-1:0]    rd_addr_q;
   logic [RD_W-1:0]    rd_last_addr;
   logic               rd_pend_q;
   logic               rd_last_pend_q;
   logic [1:0]         sk_cnt_q;
   logic [11:0]        sk_data0_q, sk_data1_q;
   logic               sk_last0_q, sk_last1_q;
   logic [CNT_W-1:0]   evt_cnt_q;
   logic [CNT_W-1:0]   trig_lost_q;

   logic accept;
   logic capture_done;
   logic skid_block;
   logic rd_en;
   logic rd_final;
   logic pop;
   logic done;
   logic hdr_pend;

   assign n_last       = n_lat_q - 1'b1;
   assign rd_last_addr = {n_last, {CH_W{1'b1}}};

   assign accept       = (state_q == S_IDLE) && trigger_i && cfg_enable_i &&
                         (cfg_nsamples_i != '0);
   assign capture_done = (state_q == S_CAPTURE) && wr_en_q && (wr_addr_q == n_last);

   // A read issued now lands in the skid one cycle later, so stop early enough
   // that the in-flight word always has a free slot.
   assign skid_block = (sk_cnt_q == 2'd2) || ((sk_cnt_q == 2'd1) && !out_ready_i);
   assign rd_en      = (state_q == S_READOUT) && !hdr_pend && !skid_block;
   assign rd_final   = rd_en && (rd_addr_q == rd_last_addr);
   assign pop        = (sk_cnt_q != 2'd0) && out_ready_i && !hdr_pend;
   assign done       = (state_q == S_FLUSH) && pop && sk_last0_q;

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (accept)       state_d = S_CAPTURE;
         S_CAPTURE: if (capture_done) state_d = S_READOUT;
         S_READOUT: if (rd_final)     state_d = S_FLUSH;
         S_FLUSH:   if (done)         state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lat_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
      end else if (accept) begin
         n_lat_q   <= cfg_nsamples_i;
         wr_en_q   <= 1'b1;
         wr_addr_q <= '0;
      end else if (capture_done) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
      end else if (wr_en_q) begin
         wr_addr_q <= wr_addr_q + 1'b1;
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr_q      <= '0;
         rd_pend_q      <= 1'b0;
         rd_last_pend_q <= 1'b0;
      end else begin
         rd_pend_q      <= rd_en;
         rd_last_pend_q <= rd_final;
         if (capture_done || rd_final) begin
            rd_addr_q <= '0;
         end else if (rd_en) begin
            rd_addr_q <= rd_addr_q + 1'b1;
         end
      end
   end

   // Skid buffer: entry 0 is the head presented on the stream.
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sk_cnt_q   <= 2'd0;
         sk_data0_q <= '0;
         sk_data1_q <= '0;
         sk_last0_q <= 1'b0;
         sk_last1_q <= 1'b0;
      end else begin
         unique case ({rd_pend_q, pop})
            2'b10: begin
               if (sk_cnt_q == 2'd0) begin
                  sk_data0_q <= buf_rd_data_i;
                  sk_last0_q <= rd_last_pend_q;
               end else begin
                  sk_data1_q <= buf_rd_data_i;
                  sk_last1_q <= rd_last_pend_q;
               end
               sk_cnt_q <= sk_cnt_q + 2'd1;
            end
            2'b01: begin
               sk_data0_q <= sk_data1_q;
               sk_last0_q <= sk_last1_q;
               sk_cnt_q   <= sk_cnt_q - 2'd1;
            end
            2'b11: begin
               if (sk_cnt_q == 2'd1) begin
                  sk_data0_q <= buf_rd_data_i;
                  sk_last0_q <= rd_last_pend_q;
               end else begin
                  sk_data0_q <= sk_data1_q;
                  sk_last0_q <= sk_last1_q;
                  sk_data1_q <= buf_rd_data_i;
                  sk_last1_q <= rd_last_pend_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_cnt_q   <= '0;
         trig_lost_q <= '0;
      end else begin
         if (done) begin
            evt_cnt_q <= evt_cnt_q + 1'b1;
         end
         if (trigger_i && (state_q != S_IDLE) && (trig_lost_q != '1)) begin
            trig_lost_q <= trig_lost_q + 1'b1;
         end
      end
   end

`ifdef ADC_EVT_HEADER_EN
   logic        hdr_pend_q;
   logic [11:0] hdr_cnt;

   assign hdr_pend = hdr_pend_q;
   assign hdr_cnt  = 12'(evt_cnt_q);

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_pend_q <= 1'b0;
      end else if (capture_done) begin
         hdr_pend_q <= 1'b1;
      end else if (out_ready_i) begin
         hdr_pend_q <= 1'b0;
      end
   end

   assign out_data_o  = hdr_pend ? {4'hA, hdr_cnt} : {4'h0, sk_data0_q};
`else
   assign hdr_pend    = 1'b0;
   assign out_data_o  = {4'h0, sk_data0_q};
`endif

   assign out_valid_o   = hdr_pend || (sk_cnt_q != 2'd0);
   assign out_last_o    = !hdr_pend && (sk_cnt_q != 2'd0) && sk_last0_q;
   assign buf_wr_en_o   = wr_en_q;
   assign buf_wr_addr_o = wr_addr_q;
   assign buf_rd_en_o   = rd_en;
   assign buf_rd_addr_o = rd_addr_q;
   assign busy_o        = (state_q != S_IDLE);
   assign evt_cnt_o     = evt_cnt_q;
   assign trig_lost_o   = trig_lost_q;

endmodule

// File: tb/tb_adc_event_sequencer.sv
// Self-checking bench for adc_event_sequencer: table of event scenarios, randomized events,
// and directed reset/lost-trigger sequences checked against a queue-based stream model.
module tb_adc_event_sequencer;

   localparam int NCH     = 64;
   localparam int NSAMP_W = 8;
   localparam int CNT_W   = 16;
   localparam int RD_W    = NSAMP_W + $clog2(NCH);

   logic               adc_clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               trigger_i = 1'b0;
   logic               cfg_enable_i = 1'b0;
   logic [NSAMP_W-1:0] cfg_nsamples_i = '0;
   logic               buf_wr_en_o;
   logic [NSAMP_W-1:0] buf_wr_addr_o;
   logic               buf_rd_en_o;
   logic [RD_W-1:0]    buf_rd_addr_o;
   logic [11:0]        buf_rd_data_i = '0;
   logic [15:0]        out_data_o;
   logic               out_valid_o;
   logic               out_ready_i = 1'b0;
   logic               out_last_o;
   logic               busy_o;
   logic [CNT_W-1:0]   evt_cnt_o;
   logic [CNT_W-1:0]   trig_lost_o;

   adc_event_sequencer #(.NCH(NCH), .NSAMP_W(NSAMP_W), .CNT_W(CNT_W)) dut (
      .adc_clk        (adc_clk),
      .rst_n          (rst_n),
      .trigger_i      (trigger_i),
      .cfg_enable_i   (cfg_enable_i),
      .cfg_nsamples_i (cfg_nsamples_i),
      .buf_wr_en_o    (buf_wr_en_o),
      .buf_wr_addr_o  (buf_wr_addr_o),
      .buf_rd_en_o    (buf_rd_en_o),
      .buf_rd_addr_o  (buf_rd_addr_o),
      .buf_rd_data_i  (buf_rd_data_i),
      .out_data_o     (out_data_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_last_o     (out_last_o),
      .busy_o         (busy_o),
      .evt_cnt_o      (evt_cnt_o),
      .trig_lost_o    (trig_lost_o)
   );

   always #5 adc_clk = ~adc_clk;

   int seed;

   function automatic logic [11:0] rd_word(input int addr);
      return 12'((addr * 37 + seed) & 'hFFF);
   endfunction

   // Sample buffer model: read data appears one cycle after the strobe.
   always @(posedge adc_clk) begin
      if (buf_rd_en_o) buf_rd_data_i <= rd_word(int'(buf_rd_addr_o));
   end

   typedef struct {
      logic en;
      int   ns;
      int   rpct;
      int   extra;
      bit   start;
   } vec_t;

   vec_t        vecs[8];
   logic [16:0] exp_q[$];
   logic [16:0] prev_word;
   bit          stalled;
   int checks, errors;
   int model_evt, model_lost;
   int exp_wr_addr, wr_count, words_seen, ready_pct;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge adc_clk);
      if (buf_wr_en_o) begin
         check("wr_addr", buf_wr_addr_o, exp_wr_addr);
         exp_wr_addr++;
         wr_count++;
      end
      if (stalled) check("stall_hold", {out_valid_o, out_last_o, out_data_o}, {1'b1, prev_word});
      if (out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got 0x%0h, expected no word", {out_last_o, out_data_o});
         end else begin
            check("word", {out_last_o, out_data_o}, exp_q.pop_front());
            words_seen++;
         end
      end
      stalled   = out_valid_o && !out_ready_i;
      prev_word = {out_last_o, out_data_o};
      @(posedge adc_clk);
      #1;
      out_ready_i = ($urandom_range(0, 99) < ready_pct);
   endtask

   task automatic build_queue(input int ns);
      exp_q.delete();
`ifdef ADC_EVT_HEADER_EN
      exp_q.push_back({1'b0, 4'hA, 12'(model_evt)});
`endif
      for (int s = 0; s < ns; s++)
         for (int ch = 0; ch < NCH; ch++)
            exp_q.push_back({(s == ns - 1) && (ch == NCH - 1), 4'h0, rd_word(s * NCH + ch)});
   endtask

   task automatic run_event(input logic en, input int ns, input int rpct, input int extra,
                            input bit start);
      int c;
      int left;
      int budget;
      seed        = int'($urandom_range(0, 4095));
      cfg_enable_i   = en;
      cfg_nsamples_i = NSAMP_W'(ns);
      ready_pct   = rpct;
      exp_wr_addr = 0;
      wr_count    = 0;
      words_seen  = 0;
      if (start) build_queue(ns);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      // configuration changes after acceptance must not matter
      cfg_nsamples_i = NSAMP_W'($urandom_range(0, 255));
      cfg_enable_i   = 1'($urandom_range(0, 1));
      if (start) begin
         c = 0;
         left = extra;
         budget = ns * NCH * 10 + 200;
         while ((exp_q.size() != 0 || busy_o) && c < budget) begin
            trigger_i = (left > 0) && (c % 4 == 3);
            if (trigger_i) left--;
            tick();
            trigger_i = 1'b0;
            c++;
         end
         check("event_done", (busy_o || exp_q.size() != 0), 0);
         model_evt  = (model_evt + 1) % (1 << CNT_W);
         model_lost = (model_lost + extra > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : model_lost + extra;
`ifdef ADC_EVT_HEADER_EN
         check("word_count", words_seen, ns * NCH + 1);
`else
         check("word_count", words_seen, ns * NCH);
`endif
         check("wr_count", wr_count, ns);
      end else begin
         for (int i = 0; i < 6; i++) tick();
         check("no_writes", wr_count, 0);
         check("no_words", words_seen, 0);
      end
      check("busy_after", busy_o, 0);
      check("evt_cnt", evt_cnt_o, model_evt);
      check("trig_lost", trig_lost_o, model_lost);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_wr_en"}, buf_wr_en_o, 0);
      check({tag, "_wr_addr"}, buf_wr_addr_o, 0);
      check({tag, "_rd_en"}, buf_rd_en_o, 0);
      check({tag, "_rd_addr"}, buf_rd_addr_o, 0);
      check({tag, "_valid"}, out_valid_o, 0);
      check({tag, "_data"}, out_data_o, 0);
      check({tag, "_last"}, out_last_o, 0);
      check({tag, "_evt_cnt"}, evt_cnt_o, 0);
      check({tag, "_trig_lost"}, trig_lost_o, 0);
   endtask

   initial begin
      vecs[0] = '{en: 1'b1, ns: 4,   rpct: 100, extra: 0, start: 1'b1};
      vecs[1] = '{en: 1'b1, ns: 4,   rpct: 50,  extra: 0, start: 1'b1};
      vecs[2] = '{en: 1'b1, ns: 2,   rpct: 100, extra: 3, start: 1'b1};
      vecs[3] = '{en: 1'b0, ns: 3,   rpct: 100, extra: 0, start: 1'b0};
      vecs[4] = '{en: 1'b1, ns: 0,   rpct: 100, extra: 0, start: 1'b0};
      vecs[5] = '{en: 1'b1, ns: 1,   rpct: 30,  extra: 1, start: 1'b1};
      vecs[6] = '{en: 1'b1, ns: 255, rpct: 100, extra: 0, start: 1'b1};
      vecs[7] = '{en: 1'b0, ns: 0,   rpct: 100, extra: 0, start: 1'b0};
      checks = 0; errors = 0; model_evt = 0; model_lost = 0;
      stalled = 1'b0; seed = 0; ready_pct = 100;

      #2;
      check_all_zero("reset");
      @(negedge adc_clk);
      rst_n = 1'b1;
      @(posedge adc_clk);
      #1;
      out_ready_i = 1'b1;

      foreach (vecs[i])
         run_event(vecs[i].en, vecs[i].ns, vecs[i].rpct, vecs[i].extra, vecs[i].start);

      for (int i = 0; i < 6; i++)
         run_event(1'b1, int'($urandom_range(1, 8)), int'($urandom_range(20, 100)),
                   int'($urandom_range(0, 2)), 1'b1);

      // Asynchronous reset in the middle of readout
      seed = int'($urandom_range(0, 4095));
      cfg_enable_i = 1'b1;
      cfg_nsamples_i = 8'd4;
      ready_pct = 60;
      exp_wr_addr = 0;
      wr_count = 0;
      words_seen = 0;
      build_queue(4);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      for (int c = 0; c < 2000 && words_seen < 20; c++) tick();
      check("reached_readout", words_seen >= 20, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      exp_q.delete();
      stalled = 1'b0;
      model_evt = 0;
      model_lost = 0;
      @(negedge adc_clk);
      rst_n = 1'b1;
      @(posedge adc_clk);
      #1;
      run_event(1'b1, 3, 100, 0, 1'b1);

      // Bring the event count to 5, then a single-sample event
      while (model_evt < 5) run_event(1'b1, 1, 100, 0, 1'b1);
      run_event(1'b1, 1, 70, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
